// File: rtl/ascii_write_arbiter_if.sv
// Requester handshakes, drain control and text-buffer write port of ascii_write_arbiter.
// The master modport is the requester side. The slave modport is the arbiter itself.
interface ascii_write_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              cpu_valid;
    logic              cpu_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              dbg_valid;
    logic              dbg_ready;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              drain;
    logic              drained;
    logic              ascii_write_en;
    logic [ADDR_W-1:0] ascii_write_address;
    logic [DATA_W-1:0] ascii_input;
    logic              addr_err;
    logic [15:0]       cpu_wr_count;
    logic [15:0]       dbg_wr_count;

    modport master (
        output cpu_valid, cpu_addr, cpu_data, dbg_valid, dbg_addr, dbg_data, drain,
        input  cpu_ready, dbg_ready, drained, ascii_write_en, ascii_write_address,
               ascii_input, addr_err, cpu_wr_count, dbg_wr_count
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_data, dbg_valid, dbg_addr, dbg_data, drain,
        output cpu_ready, dbg_ready, drained, ascii_write_en, ascii_write_address,
               ascii_input, addr_err, cpu_wr_count, dbg_wr_count
    );
endinterface

// File: rtl/ascii_write_arbiter.sv
// Shares the text-buffer write port between the CPU store path and the debug dump FSM.
// Optional per-source write counters are built when ARB_WRITE_COUNT_EN is defined.
module ascii_write_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_CELLS    = 4800
) (
    input  logic                 clk,
    input  logic                 rst,
    ascii_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW-1:0] PTR_MSB = {1'b1, {AW{1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CPU   = 2'd1;
    localparam logic [1:0] S_DBG   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [ADDR_W-1:0] addr_mem [2][FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [2][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr   [2];
    logic [PW-1:0]     rd_ptr   [2];
    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_data  [2];
    logic [1:0]        in_valid, empty, full, ready, push;

    logic [1:0]        state, state_next;
    logic [SW-1:0]     starve_cnt;
    logic              starved, grant_cpu, grant_dbg, sel, in_range, issue;
    logic [ADDR_W-1:0] pop_addr;
    logic [DATA_W-1:0] pop_data;

    logic              write_en_q, addr_err_q, drained_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0] write_data_q;

    // Index 0 is the CPU FIFO, index 1 the debug FIFO.
    always_comb begin
        in_valid   = {bus.dbg_valid, bus.cpu_valid};
        in_addr[0] = bus.cpu_addr;
        in_addr[1] = bus.dbg_addr;
        in_data[0] = bus.cpu_data;
        in_data[1] = bus.dbg_data;
        empty      = '0;
        full       = '0;
        ready      = '0;
        push       = '0;
        for (int i = 0; i < 2; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = ((wr_ptr[i] ^ rd_ptr[i]) == PTR_MSB);
            ready[i] = rst && !full[i] && !bus.drain;
            push[i]  = in_valid[i] && ready[i];
        end
    end

    always_comb begin
        starved   = (starve_cnt >= SW'(STARVE_LIMIT));
        grant_dbg = !empty[1] && (empty[0] || starved);
        grant_cpu = !empty[0] && !grant_dbg;
        sel       = grant_dbg;
        pop_addr  = addr_mem[sel][rd_ptr[sel][AW-1:0]];
        pop_data  = data_mem[sel][rd_ptr[sel][AW-1:0]];
        in_range  = (32'(pop_addr) < 32'(MAX_CELLS));
        issue     = (grant_cpu || grant_dbg) && in_range;
    end

    // The state only tracks who was served. Grants come straight from FIFO status, so a lone push strobes two edges later.
    always_comb begin
        state_next = S_IDLE;
        if (bus.drain)
            state_next = S_DRAIN;
        else if (state == S_DRAIN)
            state_next = S_IDLE;
        else if (grant_dbg)
            state_next = S_DBG;
        else if (grant_cpu)
            state_next = S_CPU;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                addr_mem[i][wr_ptr[i][AW-1:0]] <= in_addr[i];
                data_mem[i][wr_ptr[i][AW-1:0]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            state        <= S_IDLE;
            starve_cnt   <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            addr_err_q   <= 1'b0;
            drained_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
            end
            if (grant_cpu)
                rd_ptr[0] <= rd_ptr[0] + PW'(1);
            if (grant_dbg)
                rd_ptr[1] <= rd_ptr[1] + PW'(1);
            state <= state_next;
            if (grant_dbg)
                starve_cnt <= '0;
            else if (grant_cpu && !empty[1])
                starve_cnt <= starve_cnt + SW'(1);
            write_en_q <= issue;
            if (issue) begin
                write_addr_q <= pop_addr;
                write_data_q <= pop_data;
            end
            if ((grant_cpu || grant_dbg) && !in_range)
                addr_err_q <= 1'b1;
            // Empty FIFOs mean nothing is popped on this edge, so the strobe stage is clear next cycle.
            drained_q <= bus.drain && empty[0] && empty[1];
        end
    end

    assign bus.cpu_ready           = ready[0];
    assign bus.dbg_ready           = ready[1];
    assign bus.ascii_write_en      = write_en_q;
    assign bus.ascii_write_address = write_addr_q;
    assign bus.ascii_input         = write_data_q;
    assign bus.addr_err            = addr_err_q;
    assign bus.drained             = drained_q;

`ifdef ARB_WRITE_COUNT_EN
    logic [15:0] cpu_cnt, dbg_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_cnt <= '0;
            dbg_cnt <= '0;
        end else begin
            if (issue && grant_cpu)
                cpu_cnt <= cpu_cnt + 16'd1;
            if (issue && grant_dbg)
                dbg_cnt <= dbg_cnt + 16'd1;
        end
    end

    assign bus.cpu_wr_count = cpu_cnt;
    assign bus.dbg_wr_count = dbg_cnt;
`else
    assign bus.cpu_wr_count = '0;
    assign bus.dbg_wr_count = '0;
`endif
endmodule
